sb_cfg_switch_block: RTL

- Parametrised routing switch block with a double-buffered configuration chain.
- Each of CHAN_W output tracks selects one of MUX_SIZE candidate inputs.
- Select bits shift serially through a shadow chain clocked by prog_clk. They are copied into the active select registers only on a validated commit, so the routing never glitches while the chain shifts.
- Sits in the routing tile where the chain-configured switch blocks sit; ccff_head/ccff_tail daisy-chain to neighbouring blocks.

---
 rtl/sb_cfg_switch_block.sv | 111 +++++++++++
 1 files changed

// File: rtl/sb_cfg_switch_block.sv
// ============================================================================
// Module   : sb_cfg_switch_block
// Function : Routing switch block with a double-buffered serial configuration
//            chain. Select bits shift through a shadow chain on prog_clk and
//            are copied into the active select registers only on a validated
//            commit, so the routing never glitches while the chain shifts.
// Options  : SB_CFG_PARITY_EN - adds one trailing odd-parity bit to the
//            chain; a commit is accepted only if the parity checks out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_cfg_switch_block #(
    parameter  int CHAN_W   = 20,
    parameter  int MUX_SIZE = 4,
    localparam int SEL_W    = $clog2(MUX_SIZE),
    localparam int DATA_W   = CHAN_W * SEL_W,
`ifdef SB_CFG_PARITY_EN
    localparam int TOTAL    = DATA_W + 1,
`else
    localparam int TOTAL    = DATA_W,
`endif
    localparam int CNT_W    = $clog2(TOTAL + 1)
) (
    input  logic                       prog_clk,
    input  logic                       prog_reset_n,
    input  logic                       ccff_head,
    input  logic                       cfg_shift_en,
    input  logic                       cfg_commit,
    input  logic [CHAN_W*MUX_SIZE-1:0] mux_in,
    output logic [CHAN_W-1:0]          chan_out,
    output logic                       ccff_tail,
    output logic [CNT_W-1:0]           cfg_count,
    output logic                       cfg_valid,
    output logic                       cfg_err
);

    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(TOTAL);

    logic [TOTAL-1:0]  r_shadow;
    logic [DATA_W-1:0] r_active;
    logic [CNT_W-1:0]  r_count;
    logic              r_valid;
    logic              r_err;

    logic [TOTAL:0]    w_shift_cat;
    logic              w_full;
    logic              w_commit_ok;

    // New bit enters at the top; the oldest bit sits at shadow[0] and drives
    // the tail. Built via concatenation so a one-bit chain also works.
    assign w_shift_cat = {ccff_head, r_shadow};
    assign w_full      = (r_count == C_FULL_CNT);

`ifdef SB_CFG_PARITY_EN
    // Whole chain, including the trailing parity bit, must XOR to 1.
    assign w_commit_ok = w_full && (^r_shadow);
`else
    assign w_commit_ok = w_full;
`endif

    // Shadow chain, active selects and the count/valid/error bookkeeping.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_shadow <= '0;
            r_active <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else if (cfg_shift_en) begin
            r_shadow <= w_shift_cat[TOTAL:1];
            if (w_full) begin
                r_err <= 1'b1;              // shifting past a full chain
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
            if (cfg_commit) begin
                r_err <= 1'b1;              // commit colliding with a shift is dropped
            end
        end else if (cfg_commit) begin
            if (w_commit_ok) begin
                r_active <= r_shadow[DATA_W-1:0];
                r_valid  <= 1'b1;
                r_count  <= '0;
                r_err    <= 1'b0;
            end else begin
                r_err    <= 1'b1;
            end
        end
    end

    // Per-track selector: out-of-range selects and an unloaded config give 0.
    for (genvar gi = 0; gi < CHAN_W; gi++) begin : g_track
        logic [SEL_W-1:0]    w_sel;
        logic [MUX_SIZE-1:0] w_cand;
        logic                w_in_range;

        assign w_sel       = r_active[gi*SEL_W +: SEL_W];
        assign w_cand      = mux_in[gi*MUX_SIZE +: MUX_SIZE];
        assign w_in_range  = ({{(32-SEL_W){1'b0}}, w_sel} < 32'(MUX_SIZE));
        assign chan_out[gi] = r_valid && w_in_range && w_cand[w_sel];
    end : g_track

    assign ccff_tail = r_shadow[0];
    assign cfg_count = r_count;
    assign cfg_valid = r_valid;
    assign cfg_err   = r_err;

endmodule : sb_cfg_switch_block

`default_nettype wire
